// File: rtl/sram_io_bridge.sv
// sram_io_bridge
// Bridges a simple req/ack CPU port to an asynchronous SRAM (active-low
// strobes, shared tri-state data bus). It also provides one memory-mapped
// location at IO_ADDR: reads return the switch inputs and writes load the
// hex digit register.
// Optional build macro: SRAM_BYTE_WRITE_EN. When it is defined, SRAM writes
// honour byte_en through Mem_BE. When it is undefined, all lanes are always
// enabled during SRAM accesses.
// All outputs are registered. Each one is decoded from the next state, so
// strobes change cleanly on the clock edge that enters a state.
module sram_io_bridge #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter int                WAIT_CYC = 2,
    parameter int                NUM_HEX  = 4,
    parameter logic [ADDR_W-1:0] IO_ADDR  = {ADDR_W{1'b1}}
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   byte_en,
    input  logic [DATA_W-1:0]     switches,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ack,
    output logic                  busy,
    output logic [4*NUM_HEX-1:0]  hex,
    output logic                  Mem_CE,
    output logic                  Mem_OE,
    output logic                  Mem_WE,
    output logic [DATA_W/8-1:0]   Mem_BE,
    output logic [ADDR_W-1:0]     Mem_ADDR,
    inout  wire  [DATA_W-1:0]     Data
);

    localparam int BE_W  = DATA_W / 8;
    localparam int HEX_W = 4 * NUM_HEX;
    localparam int CNT_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYC);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IO       = 3'd1,
        RD       = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5,
        DONE     = 3'd6
    } state_t;

    // Zero-extends or truncates the write data to the width of the hex register.
    function automatic logic [HEX_W-1:0] hex_from_data(input logic [DATA_W-1:0] d);
        return HEX_W'(d);
    endfunction

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;

    // transaction latch (registers) and the value it will hold next cycle
    logic                we_r,    lat_we_s;
    logic [ADDR_W-1:0]   addr_r,  lat_addr_s;
    logic [DATA_W-1:0]   wdata_r, lat_wdata_s;
    logic [BE_W-1:0]     be_r,    lat_be_s;

    // registered outputs and their next values
    logic                ce_r,    ce_s;
    logic                oe_r,    oe_s;
    logic                wen_r,   wen_s;
    logic [BE_W-1:0]     mbe_r,   mbe_s;
    logic                drive_r, drive_s;
    logic                busy_r,  busy_s;
    logic                ack_r,   ack_s;
    logic [ADDR_W-1:0]   maddr_r, maddr_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic [HEX_W-1:0]    hex_r,   hex_s;

    logic                accept_s;
    logic                is_io_s;

    assign accept_s = (state_r == IDLE) && req;
    assign is_io_s  = (addr == IO_ADDR);

`ifndef SRAM_BYTE_WRITE_EN
    // byte_en has no effect on SRAM lanes in this build
    logic unused_be_s;
    assign unused_be_s = ^be_r;
`endif

    // Accept a new request only in IDLE; otherwise the latched values hold.
    always_comb begin
        lat_we_s    = we_r;
        lat_addr_s  = addr_r;
        lat_wdata_s = wdata_r;
        lat_be_s    = be_r;
        if (accept_s) begin
            lat_we_s    = we;
            lat_addr_s  = addr;
            lat_wdata_s = wdata;
            lat_be_s    = byte_en;
        end else begin
            lat_we_s    = we_r;
            lat_addr_s  = addr_r;
            lat_wdata_s = wdata_r;
            lat_be_s    = be_r;
        end
    end

    // Next-state logic and the wait counter. The counter is loaded with WAIT_CYC
    // on entry to RD or WR_PULSE and counts down to zero.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    if (is_io_s) begin
                        state_s = IO;
                    end else if (we) begin
                        state_s = WR_SETUP;
                    end else begin
                        state_s = RD;
                        cnt_s   = WAIT_LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            IO: begin
                state_s = DONE;
            end
            RD: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WR_SETUP: begin
                state_s = WR_PULSE;
                cnt_s   = WAIT_LOAD;
            end
            WR_PULSE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = WR_HOLD;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WR_HOLD: begin
                state_s = DONE;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Decode strobes, bus drive, status and captured data for the state being entered.
    always_comb begin
        ce_s    = 1'b1;
        oe_s    = 1'b1;
        wen_s   = 1'b1;
        drive_s = 1'b0;
        busy_s  = 1'b0;
        ack_s   = 1'b0;
        maddr_s = lat_addr_s;
        case (state_s)
            IDLE: begin
                maddr_s = {ADDR_W{1'b0}};
            end
            IO: begin
                busy_s = 1'b1;
            end
            RD: begin
                ce_s   = 1'b0;
                oe_s   = 1'b0;
                busy_s = 1'b1;
            end
            WR_SETUP: begin
                ce_s    = 1'b0;
                drive_s = 1'b1;
                busy_s  = 1'b1;
            end
            WR_PULSE: begin
                ce_s    = 1'b0;
                wen_s   = 1'b0;
                drive_s = 1'b1;
                busy_s  = 1'b1;
            end
            WR_HOLD: begin
                ce_s    = 1'b0;
                drive_s = 1'b1;
                busy_s  = 1'b1;
            end
            DONE: begin
                ack_s = 1'b1;
            end
            default: begin
                maddr_s = {ADDR_W{1'b0}};
            end
        endcase

`ifdef SRAM_BYTE_WRITE_EN
        if ((state_s == WR_SETUP) || (state_s == WR_PULSE) || (state_s == WR_HOLD)) begin
            mbe_s = ~lat_be_s;
        end else if (state_s == RD) begin
            mbe_s = {BE_W{1'b0}};
        end else begin
            mbe_s = {BE_W{1'b1}};
        end
`else
        if (ce_s == 1'b0) begin
            mbe_s = {BE_W{1'b0}};
        end else begin
            mbe_s = {BE_W{1'b1}};
        end
`endif

        // rdata changes only when a read completes
        if ((state_r == RD) && (state_s == DONE)) begin
            rdata_s = Data;
        end else if ((state_r == IO) && !we_r) begin
            rdata_s = switches;
        end else begin
            rdata_s = rdata_r;
        end

        if ((state_r == IO) && we_r) begin
            hex_s = hex_from_data(wdata_r);
        end else begin
            hex_s = hex_r;
        end
    end

    // State, counter, transaction latch and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            be_r    <= {BE_W{1'b0}};
            ce_r    <= 1'b1;
            oe_r    <= 1'b1;
            wen_r   <= 1'b1;
            mbe_r   <= {BE_W{1'b1}};
            drive_r <= 1'b0;
            busy_r  <= 1'b0;
            ack_r   <= 1'b0;
            maddr_r <= {ADDR_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
            hex_r   <= {HEX_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            we_r    <= lat_we_s;
            addr_r  <= lat_addr_s;
            wdata_r <= lat_wdata_s;
            be_r    <= lat_be_s;
            ce_r    <= ce_s;
            oe_r    <= oe_s;
            wen_r   <= wen_s;
            mbe_r   <= mbe_s;
            drive_r <= drive_s;
            busy_r  <= busy_s;
            ack_r   <= ack_s;
            maddr_r <= maddr_s;
            rdata_r <= rdata_s;
            hex_r   <= hex_s;
        end
    end

    assign Data     = drive_r ? wdata_r : {DATA_W{1'bz}};
    assign rdata    = rdata_r;
    assign ack      = ack_r;
    assign busy     = busy_r;
    assign hex      = hex_r;
    assign Mem_CE   = ce_r;
    assign Mem_OE   = oe_r;
    assign Mem_WE   = wen_r;
    assign Mem_BE   = mbe_r;
    assign Mem_ADDR = maddr_r;

endmodule

// File: doc/sram_io_bridge.md
SRAM_IO_BRIDGE -- requirements
Module: sram_io_bridge

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning CPU/SRAM data width (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 20, meaning SRAM address width.
REQ-003 The block SHALL have parameter WAIT_CYC, default 2, meaning extra strobe cycles per SRAM access (0 legal).
REQ-004 The block SHALL have parameter NUM_HEX, default 4, meaning the number of 4-bit hex digit outputs.
REQ-005 The block SHALL have parameter IO_ADDR, default all-ones (ADDR_W bits), meaning the memory-mapped switch/hex address.
REQ-006 The block SHALL have port Clk, input, 1 bit: the single clock, all state on rising edge.
REQ-007 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have the following ports, one per line:
- req, input, 1: transaction request.
- we, input, 1: 1=write, 0=read.
- addr, input, ADDR_W: transaction address.
- wdata, input, DATA_W: write data.
- byte_en, input, DATA_W/8: active-high lane enables.
- switches, input, DATA_W: switch inputs.
- rdata, output, DATA_W: read data.
- ack, output, 1: one-cycle completion pulse.
- busy, output, 1: transaction in progress.
- hex, output, 4*NUM_HEX: hex digit register.
- Mem_CE, Mem_OE, Mem_WE, output, 1 each: active-low SRAM strobes.
- Mem_BE, output, DATA_W/8: active-low byte lanes (lane 0 = LB).
- Mem_ADDR, output, ADDR_W: SRAM address.
- Data, inout wire, DATA_W: SRAM data bus.

Function
REQ-009 The FSM SHALL have states IDLE, IO, RD, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
REQ-010 In IDLE with req=1, the block SHALL latch addr, we, wdata and byte_en, and set busy=1 from the next cycle until ack.
REQ-011 A request with addr==IO_ADDR SHALL go to IO, never assert any Mem_* strobe, and go to DONE next cycle; a read returns switches, a write loads the hex register from wdata[4*NUM_HEX-1:0] (zero-padded if DATA_W is narrower).
REQ-012 An SRAM read SHALL hold RD for WAIT_CYC+1 cycles with Mem_CE=0 and Mem_OE=0, capture Data into rdata on the last RD cycle, then go to DONE.
REQ-013 An SRAM write SHALL go through the following sequence:
- WR_SETUP: 1 cycle, CE=0, WE=1.
- WR_PULSE: WAIT_CYC+1 cycles, CE=0, WE=0.
- WR_HOLD: 1 cycle, CE=0, WE=1.
- Then DONE.
REQ-014 Data SHALL be driven with latched wdata only in WR_SETUP, WR_PULSE and WR_HOLD, and be high-Z in all other states; Mem_OE SHALL be 1 throughout writes.
REQ-015 DONE SHALL last 1 cycle with ack=1, busy=0 and return to IDLE; rdata SHALL hold its value until the next read completes.
REQ-016 Latency from the req sample edge to ack SHALL be: IO = 2 cycles, read = WAIT_CYC+2 cycles, write = WAIT_CYC+4 cycles.
REQ-017 Requests and input changes SHALL be ignored while busy; if req is still high in IDLE after DONE, a new transaction SHALL start (back-to-back throughput, no lost cycle beyond IDLE).
REQ-018 Mem_ADDR SHALL equal the latched address whenever not in IDLE, and be 0 in IDLE.
REQ-019 The wait counter SHALL be sized to hold WAIT_CYC, and WAIT_CYC=0 SHALL give single-cycle RD and WR_PULSE.

Reset
REQ-020 When Reset=0, the block SHALL asynchronously enter IDLE and set:
- Mem_CE=Mem_OE=Mem_WE=1, Mem_BE all 1.
- Data high-Z.
- ack=0, busy=0, rdata=0, hex=0, Mem_ADDR=0.
REQ-021 Reset asserted mid-transaction SHALL abort it with no ack, and the first request after release SHALL be serviced normally.

Configuration
REQ-022 With macro SRAM_BYTE_WRITE_EN defined, Mem_BE SHALL equal ~latched byte_en during write states, and all 0 during reads.
REQ-023 Without SRAM_BYTE_WRITE_EN, Mem_BE SHALL be all 0 whenever CE=0 and byte_en SHALL be ignored; IO writes SHALL be unaffected in both cases.

Verification
REQ-024 With WAIT_CYC=2, a read of 0x00010 whose SRAM model returns 0x3C5A SHALL give ack 4 cycles after the req edge, rdata=0x3C5A and OE low for exactly 3 cycles.
REQ-025 A write of 0xBEEF to 0x00020 with WAIT_CYC=2 SHALL give WE low for exactly 3 cycles, Data=0xBEEF from setup through hold, ack at cycle 6, and Data high-Z after.
REQ-026 A write of 0x1234 to IO_ADDR SHALL give hex=0x1234 with no CE pulse; a read of IO_ADDR with switches=0x00A5 SHALL give rdata=0x00A5 and ack at cycle 2.
REQ-027 With SRAM_BYTE_WRITE_EN defined and byte_en=2'b01, Mem_BE SHALL be 2'b10 during the write; without the macro it SHALL be 2'b00.
REQ-028 Reset pulsed low during WR_PULSE SHALL force WE=1, CE=1 and Data high-Z immediately with no ack, and a following read SHALL complete in 4 cycles.
REQ-029 req held high across two reads with WAIT_CYC=0 SHALL give two ack pulses 3 cycles apart.
